// File: rtl/cache_2way_wb_if.sv
// cache_2way_wb_if: bundles the core-side request port and the word-addressed
// data-memory port of the 2-way write-back cache.
//   core side  : cache_csn, cache_wen, cache_addr, cache_dout -> cache
//                cache_di, cache_miss                         <- cache
//   memory side: d_mem_csn, d_mem_wen, d_mem_addr, d_mem_dout, d_mem_be <- cache
//                d_mem_di (valid one cycle after the address) -> cache
// modport slave is the cache's view; modport master is the core+memory view.
interface cache_2way_wb_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic              cache_csn;
  logic              cache_wen;
  logic [ADDR_W-1:0] cache_addr;
  logic [DATA_W-1:0] cache_dout;
  logic [DATA_W-1:0] cache_di;
  logic              cache_miss;

  logic              d_mem_csn;
  logic              d_mem_wen;
  logic [ADDR_W-1:0] d_mem_addr;
  logic [DATA_W-1:0] d_mem_dout;
  logic [DATA_W-1:0] d_mem_di;
  logic [3:0]        d_mem_be;

  modport slave (
    input  cache_csn, cache_wen, cache_addr, cache_dout, d_mem_di,
    output cache_di, cache_miss, d_mem_csn, d_mem_wen, d_mem_addr, d_mem_dout, d_mem_be
  );

  modport master (
    output cache_csn, cache_wen, cache_addr, cache_dout, d_mem_di,
    input  cache_di, cache_miss, d_mem_csn, d_mem_wen, d_mem_addr, d_mem_dout, d_mem_be
  );
endinterface

// File: rtl/cache_2way_wb.sv
// cache_2way_wb: 2-way set-associative, write-back, write-allocate data cache
// with one LRU bit per set and burst eviction of dirty lines.
// Ports:
//   clk     - clock, rising edge
//   rst     - asynchronous active-high reset
//   bus     - cache_2way_wb_if.slave: core request/response and data-memory port
//   hitnum  - hit counter
//   missnum - miss counter
//   wbnum   - dirty-eviction counter
// Flow: IDLE serves hits in one cycle; a miss goes through WB (only for a dirty
// victim, WORDS write cycles), FILL (WORDS read cycles plus one capture cycle)
// and DONE (merge write / return read word) before returning to IDLE.
module cache_2way_wb #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int SETS   = 8,
  parameter int WORDS  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  cache_2way_wb_if.slave        bus,
  output logic [31:0]           hitnum,
  output logic [31:0]           missnum,
  output logic [31:0]           wbnum
);

  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
  localparam int LINES = SETS * WORDS;

  localparam logic [OFF_W:0] CNT_WB_LAST   = (OFF_W+1)'(WORDS - 1);
  localparam logic [OFF_W:0] CNT_FILL_LAST = (OFF_W+1)'(WORDS);

  typedef enum logic [1:0] {IDLE, WB, FILL, DONE} state_t;

  state_t state, state_nx;

  // Per-way state; way is the first (unpacked) dimension.
  logic [SETS-1:0]   valid [2];
  logic [SETS-1:0]   dirty [2];
  logic [SETS-1:0]   lru;
  logic [TAG_W-1:0]  tag_mem  [2][SETS];
  logic [DATA_W-1:0] data_mem [2][LINES];

  // Latched miss request.
  logic [ADDR_W-1:0] req_addr;
  logic              req_wen;
  logic [DATA_W-1:0] req_data;
  logic              vic_way;
  logic              dropped;   // core released CACHE_CSN during WB/FILL
  logic [OFF_W:0]    cnt;
  logic [DATA_W-1:0] di_q;

  // Incoming address fields.
  logic [OFF_W-1:0] in_off;
  logic [IDX_W-1:0] in_idx;
  logic [TAG_W-1:0] in_tag;
  assign in_off = bus.cache_addr[OFF_W-1:0];
  assign in_idx = bus.cache_addr[OFF_W +: IDX_W];
  assign in_tag = bus.cache_addr[ADDR_W-1 -: TAG_W];

  // Latched address fields.
  logic [OFF_W-1:0] r_off;
  logic [IDX_W-1:0] r_idx;
  logic [TAG_W-1:0] r_tag;
  assign r_off = req_addr[OFF_W-1:0];
  assign r_idx = req_addr[OFF_W +: IDX_W];
  assign r_tag = req_addr[ADDR_W-1 -: TAG_W];

  logic [OFF_W-1:0] cnt_off;
  logic [OFF_W-1:0] cnt_prev;
  assign cnt_off  = cnt[OFF_W-1:0];
  assign cnt_prev = cnt_off - OFF_W'(1);   // word captured this FILL cycle

  // Lookup and victim choice for the incoming request.
  logic hit0, hit1, hit, hit_way;
  logic vic_sel, vic_dirty;
  logic [DATA_W-1:0] hit_word;
  assign hit0     = valid[0][in_idx] && (tag_mem[0][in_idx] == in_tag);
  assign hit1     = valid[1][in_idx] && (tag_mem[1][in_idx] == in_tag);
  assign hit      = hit0 | hit1;
  assign hit_way  = hit1;
  assign hit_word = data_mem[hit_way][{in_idx, in_off}];
  // Invalid way first (way 0 preferred), otherwise the LRU way.
  assign vic_sel   = !valid[0][in_idx] ? 1'b0 :
                     !valid[1][in_idx] ? 1'b1 : lru[in_idx];
  assign vic_dirty = valid[vic_sel][in_idx] && dirty[vic_sel][in_idx];

  logic start, hit_req;
  assign start   = (state == IDLE) && !bus.cache_csn;
  assign hit_req = start && hit;

  logic              miss;
  logic [DATA_W-1:0] di_nx;

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_nx       = state;
    miss           = 1'b0;
    di_nx          = di_q;
    bus.d_mem_csn  = 1'b1;
    bus.d_mem_wen  = 1'b1;
    bus.d_mem_addr = '0;
    bus.d_mem_dout = '0;
    unique case (state)
      IDLE: begin
        if (!bus.cache_csn) begin
          if (hit) begin
            if (bus.cache_wen) di_nx = hit_word;
          end else begin
            miss     = 1'b1;
            state_nx = vic_dirty ? WB : FILL;
          end
        end
      end
      WB: begin
        miss           = 1'b1;
        bus.d_mem_csn  = 1'b0;
        bus.d_mem_wen  = 1'b0;
        bus.d_mem_addr = {tag_mem[vic_way][r_idx], r_idx, cnt_off};
        bus.d_mem_dout = data_mem[vic_way][{r_idx, cnt_off}];
        if (cnt == CNT_WB_LAST) state_nx = FILL;
      end
      FILL: begin
        miss = 1'b1;
        if (cnt != CNT_FILL_LAST) begin
          bus.d_mem_csn  = 1'b0;
          bus.d_mem_addr = {r_tag, r_idx, cnt_off};
        end else begin
          state_nx = DONE;
        end
      end
      DONE: begin
        if (!dropped && req_wen) di_nx = data_mem[vic_way][{r_idx, r_off}];
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.cache_miss = miss && !rst;
  assign bus.cache_di   = di_nx;
  assign bus.d_mem_be   = 4'b1111;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      valid[0] <= '0;
      valid[1] <= '0;
      dirty[0] <= '0;
      dirty[1] <= '0;
      lru      <= '0;
      hitnum   <= '0;
      missnum  <= '0;
      wbnum    <= '0;
      di_q     <= '0;
      req_addr <= '0;
      req_wen  <= 1'b1;
      req_data <= '0;
      vic_way  <= 1'b0;
      dropped  <= 1'b0;
      cnt      <= '0;
    end else begin
      state <= state_nx;
      di_q  <= di_nx;
      unique case (state)
        IDLE: begin
          if (hit_req) begin
            hitnum      <= hitnum + 32'd1;
            lru[in_idx] <= ~hit_way;
            if (!bus.cache_wen) dirty[hit_way][in_idx] <= 1'b1;
          end else if (start) begin
            missnum  <= missnum + 32'd1;
            req_addr <= bus.cache_addr;
            req_wen  <= bus.cache_wen;
            req_data <= bus.cache_dout;
            vic_way  <= vic_sel;
            dropped  <= 1'b0;
            cnt      <= '0;
            if (vic_dirty) wbnum <= wbnum + 32'd1;
          end
        end
        WB: begin
          cnt <= (cnt == CNT_WB_LAST) ? '0 : cnt + 1'b1;
          if (bus.cache_csn) dropped <= 1'b1;
        end
        FILL: begin
          cnt <= cnt + 1'b1;
          if (bus.cache_csn) dropped <= 1'b1;
          if (cnt == CNT_FILL_LAST) begin
            valid[vic_way][r_idx] <= 1'b1;
            dirty[vic_way][r_idx] <= 1'b0;
          end
        end
        DONE: begin
          lru[r_idx] <= ~vic_way;
          if (!dropped && !req_wen) dirty[vic_way][r_idx] <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // NOTE: tag and data arrays carry no reset; valid bits alone decide whether
  // their contents mean anything, and leaving them unreset lets them map to RAM.
  always_ff @(posedge clk) begin
    unique case (state)
      IDLE: begin
        if (hit_req && !bus.cache_wen)
          data_mem[hit_way][{in_idx, in_off}] <= bus.cache_dout;
      end
      FILL: begin
        if (cnt != '0) data_mem[vic_way][{r_idx, cnt_prev}] <= bus.d_mem_di;
        if (cnt == CNT_FILL_LAST) tag_mem[vic_way][r_idx] <= r_tag;
      end
      DONE: begin
        if (!dropped && !req_wen) data_mem[vic_way][{r_idx, r_off}] <= req_data;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cache_2way_wb.sv
// tb_cache_2way_wb: directed plus randomized bench for cache_2way_wb. A
// line-level reference model (per-set recency queue of lines, backing memory
// array) predicts read data, stall length, memory traffic and counters.
module tb_cache_2way_wb;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam int SETS   = 8;
  localparam int WORDS  = 4;

  logic clk = 1'b0;
  logic rst;
  logic [31:0] hitnum, missnum, wbnum;

  always #5 clk = ~clk;

  cache_2way_wb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  cache_2way_wb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SETS(SETS), .WORDS(WORDS)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .hitnum  (hitnum),
    .missnum (missnum),
    .wbnum   (wbnum)
  );

  // Environment memory and transaction log.
  typedef struct packed {
    logic        we;
    logic [11:0] addr;
    logic [31:0] data;
  } xact_t;

  logic [31:0] mem [4096];
  xact_t seen_q[$];
  xact_t exp_q[$];

  always @(posedge clk) begin
    if (!rst && !bus.d_mem_csn) begin
      if (!bus.d_mem_wen) begin
        mem[bus.d_mem_addr] <= bus.d_mem_dout;
        seen_q.push_back('{we: 1'b1, addr: bus.d_mem_addr, data: bus.d_mem_dout});
      end else begin
        bus.d_mem_di <= mem[bus.d_mem_addr];
        seen_q.push_back('{we: 1'b0, addr: bus.d_mem_addr, data: 32'h0});
      end
    end
  end

  // Reference model: each set holds up to two lines, most recent at the front.
  typedef struct packed {
    logic [6:0]       tag;
    logic             dirty;
    logic [3:0][31:0] w;
  } line_t;

  line_t       set_q [SETS][$];
  logic [31:0] ref_mem [4096];
  int m_hits, m_misses, m_wbs;
  int checks, failures;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < SETS; s++) set_q[s].delete();
    m_hits = 0; m_misses = 0; m_wbs = 0;
  endtask

  task automatic model_access(input logic [11:0] a, input bit wr, input logic [31:0] wd,
                              input bit drop, output logic [31:0] rd, output int cyc);
    logic [2:0] idx;
    logic [6:0] tg;
    logic [1:0] off;
    int found;
    line_t ln, vic;
    idx = a[4:2]; tg = a[11:5]; off = a[1:0];
    found = -1;
    for (int i = 0; i < set_q[idx].size(); i++)
      if (set_q[idx][i].tag == tg) found = i;
    if (found >= 0) begin
      ln = set_q[idx][found];
      set_q[idx].delete(found);
      m_hits++;
      cyc = 0;
    end else begin
      m_misses++;
      cyc = WORDS + 2;
      if (set_q[idx].size() == 2) begin
        vic = set_q[idx].pop_back();
        if (vic.dirty) begin
          m_wbs++;
          cyc = 2 * WORDS + 2;
          for (int i = 0; i < WORDS; i++) begin
            exp_q.push_back('{we: 1'b1, addr: {vic.tag, idx, 2'(i)}, data: vic.w[i]});
            ref_mem[{vic.tag, idx, 2'(i)}] = vic.w[i];
          end
        end
      end
      ln.tag = tg;
      ln.dirty = 1'b0;
      for (int i = 0; i < WORDS; i++) begin
        ln.w[i] = ref_mem[{tg, idx, 2'(i)}];
        exp_q.push_back('{we: 1'b0, addr: {tg, idx, 2'(i)}, data: 32'h0});
      end
    end
    rd = ln.w[off];
    if (wr && !drop) begin
      ln.w[off] = wd;
      ln.dirty = 1'b1;
    end
    set_q[idx].push_front(ln);
  endtask

  task automatic check_traffic(input string tag);
    check({tag, " mem_ops"}, 32'(seen_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < seen_q.size() && i < exp_q.size(); i++) begin
      check({tag, " mem_kind_addr"}, {19'd0, seen_q[i].we, seen_q[i].addr},
            {19'd0, exp_q[i].we, exp_q[i].addr});
      if (exp_q[i].we) check({tag, " mem_wdata"}, seen_q[i].data, exp_q[i].data);
    end
    seen_q.delete();
    exp_q.delete();
  endtask

  // One core access; drop_at > 0 releases CACHE_CSN after that many stall cycles.
  task automatic do_access(input string tag, input logic [11:0] a, input bit wr,
                           input logic [31:0] wd, input int drop_at = 0);
    logic [31:0] erd;
    int ecyc, cyc;
    model_access(a, wr, wd, drop_at > 0, erd, ecyc);
    @(negedge clk);
    bus.cache_csn  = 1'b0;
    bus.cache_wen  = ~wr;
    bus.cache_addr = a;
    bus.cache_dout = wd;
    #1;
    if (ecyc == 0) check({tag, " hit_no_mem"}, 32'(bus.d_mem_csn), 32'd1);
    cyc = 0;
    while (bus.cache_miss === 1'b1 && cyc < 40) begin
      @(negedge clk);
      #1;
      cyc++;
      if (drop_at > 0 && cyc == drop_at) bus.cache_csn = 1'b1;
    end
    check({tag, " miss_cycles"}, 32'(cyc), 32'(ecyc));
    if (!wr) check({tag, " rdata"}, bus.cache_di, erd);
    @(posedge clk);
    #1;
    bus.cache_csn = 1'b1;
    check_traffic(tag);
  endtask

  task automatic check_counters(input string tag);
    check({tag, " hitnum"},  hitnum,  32'(m_hits));
    check({tag, " missnum"}, missnum, 32'(m_misses));
    check({tag, " wbnum"},   wbnum,   32'(m_wbs));
  endtask

  initial begin
    logic [11:0] a;
    checks = 0;
    failures = 0;
    for (int i = 0; i < 4096; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    model_reset();
    bus.cache_csn  = 1'b1;
    bus.cache_wen  = 1'b1;
    bus.cache_addr = '0;
    bus.cache_dout = '0;
    rst = 1'b1;
    #12;
    check("reset d_mem_csn",  32'(bus.d_mem_csn),  32'd1);
    check("reset d_mem_wen",  32'(bus.d_mem_wen),  32'd1);
    check("reset d_mem_addr", 32'(bus.d_mem_addr), 32'd0);
    check("reset cache_miss", 32'(bus.cache_miss), 32'd0);
    check("reset cache_di",   bus.cache_di,        32'd0);
    check("reset d_mem_be",   32'(bus.d_mem_be),   32'hF);
    check_counters("reset");
    @(negedge clk);
    rst = 1'b0;

    // Clean miss, then a hit on the same line.
    do_access("rd_041_miss", 12'h041, 1'b0, 32'h0);
    check("after first miss missnum", missnum, 32'd1);
    do_access("rd_041_hit", 12'h041, 1'b0, 32'h0);
    check("after hit hitnum", hitnum, 32'd1);

    // Write hit, read back.
    do_access("wr_042_hit", 12'h042, 1'b1, 32'hDEADBEEF);
    do_access("rd_042_hit", 12'h042, 1'b0, 32'h0);

    // Dirty eviction of the 0x040 line.
    do_access("rd_080_miss", 12'h080, 1'b0, 32'h0);
    do_access("rd_080_touch", 12'h080, 1'b0, 32'h0);
    do_access("rd_0c0_wb", 12'h0C0, 1'b0, 32'h0);
    check("after wb wbnum", wbnum, 32'd1);
    check("wb wrote back 0x042", mem[12'h042], 32'hDEADBEEF);

    // LRU order.
    do_access("lru_100", 12'h100, 1'b0, 32'h0);
    do_access("lru_140", 12'h140, 1'b0, 32'h0);
    do_access("lru_100_hit", 12'h100, 1'b0, 32'h0);
    do_access("lru_180", 12'h180, 1'b0, 32'h0);
    do_access("lru_100_keep", 12'h100, 1'b0, 32'h0);

    // Write-allocate miss.
    do_access("wr_201_miss", 12'h201, 1'b1, 32'h12345678);
    do_access("rd_201_hit", 12'h201, 1'b0, 32'h0);
    check_counters("directed");

    // Core releases the request mid-FILL: no merge, line still allocated.
    do_access("drop_3e5", 12'h3E5, 1'b1, 32'hA5A5A5A5, 3);
    do_access("drop_3e5_rd", 12'h3E5, 1'b0, 32'h0);

    // Randomized traffic over a few tags per set to force conflicts.
    for (int n = 0; n < 120; n++) begin
      a = {7'(16 + $urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      do_access($sformatf("rand%0d", n), a, 1'($urandom_range(0, 1)), $urandom);
    end
    check_counters("random");

    // Reset during FILL cycle 2.
    @(negedge clk);
    bus.cache_csn  = 1'b0;
    bus.cache_wen  = 1'b1;
    bus.cache_addr = 12'h30A;
    repeat (3) @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midfill rst d_mem_csn",  32'(bus.d_mem_csn),  32'd1);
    check("midfill rst cache_miss", 32'(bus.cache_miss), 32'd0);
    check("midfill rst cache_di",   bus.cache_di,        32'd0);
    model_reset();
    check_counters("midfill rst");
    check("midfill rst mem_ops", 32'(seen_q.size()), 32'd2);
    seen_q.delete();
    exp_q.delete();
    bus.cache_csn = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    do_access("rd_30a_after_rst", 12'h30A, 1'b0, 32'h0);
    check_counters("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
